// File: rtl/wb_boot_loader.sv
// wb_boot_loader
//   Boot-time image loader. After reset it holds the CPU in reset for
//   RST_HOLD cycles. It then copies min(num_words_i, MAX_WORDS) words from a
//   combinational-read source memory into target memory. The copy uses
//   classic Wishbone B3 single writes, one word per bus cycle. The CPU reset
//   is released only when the copy completes. An error or a response timeout
//   leaves the CPU held and raises error_o.
//
//   Optional feature (macro WB_BOOT_LOADER_VERIFY_EN): each written word is
//   read back from the same address and compared before the loader moves on.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   num_words_i          image length in words (sampled when HOLD ends)
//   src_addr_o           source word index (registered)
//   src_data_i           source word at src_addr_o (same-cycle read)
//   wbm_*                Wishbone B3 classic master port
//   cpu_rst_o            CPU reset, active high
//   done_o / error_o     terminal status flags
//   words_loaded_o       number of words successfully committed
module wb_boot_loader #(
  parameter int unsigned     DW          = 32,
  parameter int unsigned     AW          = 32,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int unsigned     MAX_WORDS   = 1024,
  parameter int unsigned     RST_HOLD    = 16,
  parameter int unsigned     ACK_TIMEOUT = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [$clog2(MAX_WORDS+1)-1:0] num_words_i,
  output logic [$clog2(MAX_WORDS)-1:0]   src_addr_o,
  input  logic [DW-1:0]                  src_data_i,
  output logic [AW-1:0]                  wbm_adr_o,
  output logic [DW-1:0]                  wbm_dat_o,
  output logic [DW/8-1:0]                wbm_sel_o,
  output logic                           wbm_we_o,
  output logic                           wbm_cyc_o,
  output logic                           wbm_stb_o,
  output logic [2:0]                     wbm_cti_o,
  output logic [1:0]                     wbm_bte_o,
  input  logic [DW-1:0]                  wbm_dat_i,
  input  logic                           wbm_ack_i,
  input  logic                           wbm_err_i,
  output logic                           cpu_rst_o,
  output logic                           done_o,
  output logic                           error_o,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded_o
);

  localparam int unsigned NW = $clog2(MAX_WORDS + 1);
  localparam int unsigned IW = $clog2(MAX_WORDS);
  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit            TMO_EN    = (ACK_TIMEOUT != 0);
  localparam logic [NW-1:0] MAX_N     = NW'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HOLD,
    S_FETCH,
    S_WRITE,
`ifdef WB_BOOT_LOADER_VERIFY_EN
    S_VSETUP,
    S_VERIFY,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [NW-1:0] n_words;

  // Fixed bus attributes: full-word classic cycles only.
  assign wbm_sel_o = '1;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  logic [NW-1:0] n_clamped;
  logic          last_word;
  logic          timed_out;
  logic          resp_fail;

  assign n_clamped = (num_words_i > MAX_N) ? MAX_N : num_words_i;
  // The word in flight is the last one when it is the n-th to be committed.
  assign last_word = (words_loaded_o == n_words - NW'(1));
  // An ack in the final timeout cycle still counts as a response.
  assign timed_out = TMO_EN && (tmo_cnt == TMO_LAST) && !wbm_ack_i;
  // err takes precedence over ack when both arrive together.
  assign resp_fail = wbm_err_i || timed_out;

`ifndef WB_BOOT_LOADER_VERIFY_EN
  // Read data only matters when read-back verification is built in.
  logic unused_rdata;
  assign unused_rdata = ^wbm_dat_i;
`endif

  // NOTE: all state below is updated with non-blocking assignments, so every
  // branch reads the pre-edge values of the registers it tests.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= S_HOLD;
      hold_cnt       <= '0;
      tmo_cnt        <= '0;
      n_words        <= '0;
      src_addr_o     <= '0;
      words_loaded_o <= '0;
      wbm_adr_o      <= BASE_ADDR;
      wbm_dat_o      <= '0;
      wbm_we_o       <= 1'b0;
      wbm_cyc_o      <= 1'b0;
      wbm_stb_o      <= 1'b0;
      cpu_rst_o      <= 1'b1;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            n_words <= n_clamped;
            if (n_clamped == '0) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        // src_addr_o has been stable for a full cycle, so src_data_i is valid.
        S_FETCH: begin
          wbm_dat_o <= src_data_i;
          wbm_adr_o <= BASE_ADDR + AW'(src_addr_o) * AW'(DW / 8);
          wbm_we_o  <= 1'b1;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          tmo_cnt   <= '0;
          state     <= S_WRITE;
        end

        S_WRITE: begin
          if (resp_fail) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            error_o   <= 1'b1;
            state     <= S_ERROR;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
`ifdef WB_BOOT_LOADER_VERIFY_EN
            state     <= S_VSETUP;
`else
            words_loaded_o <= words_loaded_o + NW'(1);
            if (last_word) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              src_addr_o <= src_addr_o + IW'(1);
              state      <= S_FETCH;
            end
`endif
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

`ifdef WB_BOOT_LOADER_VERIFY_EN
        // One idle bus cycle separates the write from its read-back.
        S_VSETUP: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          tmo_cnt   <= '0;
          state     <= S_VERIFY;
        end

        S_VERIFY: begin
          if (resp_fail || (wbm_ack_i && (wbm_dat_i != wbm_dat_o))) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            error_o   <= 1'b1;
            state     <= S_ERROR;
          end else if (wbm_ack_i) begin
            wbm_cyc_o      <= 1'b0;
            wbm_stb_o      <= 1'b0;
            words_loaded_o <= words_loaded_o + NW'(1);
            if (last_word) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              src_addr_o <= src_addr_o + IW'(1);
              state      <= S_FETCH;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
`endif

        // DONE and ERROR are terminal; only wb_rst_i leaves them.
        default: ;
      endcase
    end
  end

endmodule
